// File: rtl/alu_seq_param.sv
`timescale 1ns/1ps
// alu_seq_param: WIDTH-bit registered ALU with start/done handshake.
// Single-cycle logic/arith/shift ops and iterative multiply/divide into HI/LO.
module alu_seq_param #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [5:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Overflow,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = $clog2(WIDTH + 1);
    localparam int unsigned PW  = 2 * WIDTH;

    localparam logic [5:0] OP_SLL   = 6'b000000;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLTU  = 6'b101011;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

    state_t state, state_nx;

    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] acc, acc_nx;      // product high half / partial remainder
    logic [WIDTH-1:0] quo, quo_nx;      // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] dsr, dsr_nx;      // multiplicand / divisor magnitude
    logic             is_div, div_nx;
    logic             neg_q, negq_nx;   // product / quotient must be negated
    logic             neg_r, negr_nx;   // remainder must be negated
    logic             div0, dz_nx;      // divide by zero
    logic [WIDTH-1:0] res_nx, hi_nx, lo_nx;
    logic             zero_nx, ovf_nx, busy_nx, done_nx;

    logic             is_multi, is_signed_op, is_div_op;
    logic [WIDTH-1:0] sc_res, sum, diff, a_op, b_op;
    logic             sc_ovf;
    logic [SHW-1:0]   shamt;

    logic [WIDTH:0]   msum;
    logic [WIDTH-1:0] acc_mul, quo_mul, acc_div, quo_div, dsub;
    logic             ge;
    logic [PW-1:0]    prod, prod_s;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: IDLE -> CALC for WIDTH iterations -> FIX -> IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (Start && is_multi) state_nx = CALC;
            CALC:    if (cnt == CW'(1)) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Opcode decode, single-cycle results and latched multi-cycle operands
    always_comb begin
        is_multi     = (ALUControl == OP_MULT) || (ALUControl == OP_MULTU) ||
                       (ALUControl == OP_DIV)  || (ALUControl == OP_DIVU);
        is_signed_op = (ALUControl == OP_MULT) || (ALUControl == OP_DIV);
        is_div_op    = (ALUControl == OP_DIV)  || (ALUControl == OP_DIVU);
        a_op  = (is_signed_op && A[WIDTH-1]) ? -A : A;
        b_op  = (is_signed_op && B[WIDTH-1]) ? -B : B;
        sum   = A + B;
        diff  = A - B;
        shamt = B[SHW-1:0];
        sc_res = '0;
        sc_ovf = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  sc_res = A & B;
            OP_OR:   sc_res = A | B;
            OP_XOR:  sc_res = A ^ B;
            OP_NOR:  sc_res = ~(A | B);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLL:  sc_res = A << shamt;
            OP_SRL:  sc_res = A >> shamt;
            OP_SRA:  sc_res = WIDTH'($signed(A) >>> shamt);
            OP_MFHI: sc_res = Hi;
            OP_MFLO: sc_res = Lo;
            default: sc_res = '0;
        endcase
    end

    // One shift-add / restoring-divide iteration and the final sign fix
    always_comb begin
        msum    = {1'b0, acc} + (quo[0] ? {1'b0, dsr} : {(WIDTH+1){1'b0}});
        acc_mul = msum[WIDTH:1];
        quo_mul = {msum[0], quo[WIDTH-1:1]};

        ge      = ({acc, quo[WIDTH-1]} >= {1'b0, dsr});
        dsub    = WIDTH'({acc, quo[WIDTH-1]} - {1'b0, dsr});
        acc_div = ge ? dsub : {acc[WIDTH-2:0], quo[WIDTH-1]};
        quo_div = {quo[WIDTH-2:0], ge};

        prod    = {acc, quo};
        prod_s  = neg_q ? -prod : prod;
        if (is_div) begin
            fix_lo = div0 ? '1 : (neg_q ? -quo : quo);
            fix_hi = neg_r ? -acc : acc;
        end else begin
            fix_hi = prod_s[PW-1:WIDTH];
            fix_lo = prod_s[WIDTH-1:0];
        end
    end

    // Output / datapath next values per state
    always_comb begin
        res_nx  = ALUResult;
        zero_nx = Zero;
        ovf_nx  = Overflow;
        hi_nx   = Hi;
        lo_nx   = Lo;
        busy_nx = Busy;
        done_nx = 1'b0;
        cnt_nx  = cnt;
        acc_nx  = acc;
        quo_nx  = quo;
        dsr_nx  = dsr;
        div_nx  = is_div;
        negq_nx = neg_q;
        negr_nx = neg_r;
        dz_nx   = div0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (is_multi) begin
                        busy_nx = 1'b1;
                        cnt_nx  = CW'(WIDTH);
                        acc_nx  = '0;
                        quo_nx  = a_op;
                        dsr_nx  = b_op;
                        div_nx  = is_div_op;
                        negq_nx = is_signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                        negr_nx = is_signed_op && A[WIDTH-1];
                        dz_nx   = is_div_op && (B == '0);
                    end else begin
                        res_nx  = sc_res;
                        zero_nx = (sc_res == '0);
                        ovf_nx  = sc_ovf;
                        done_nx = 1'b1;
                    end
                end
            end
            CALC: begin
                cnt_nx = cnt - CW'(1);
                if (is_div) begin
                    acc_nx = acc_div;
                    quo_nx = quo_div;
                end else begin
                    acc_nx = acc_mul;
                    quo_nx = quo_mul;
                end
            end
            FIX: begin
                hi_nx   = fix_hi;
                lo_nx   = fix_lo;
                res_nx  = fix_lo;
                zero_nx = (fix_lo == '0);
                ovf_nx  = 1'b0;
                busy_nx = 1'b0;
                done_nx = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ALUResult <= '0;
            Zero      <= 1'b1;
            Overflow  <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            quo       <= '0;
            dsr       <= '0;
            is_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div0      <= 1'b0;
        end else begin
            ALUResult <= res_nx;
            Zero      <= zero_nx;
            Overflow  <= ovf_nx;
            Hi        <= hi_nx;
            Lo        <= lo_nx;
            Busy      <= busy_nx;
            Done      <= done_nx;
            cnt       <= cnt_nx;
            acc       <= acc_nx;
            quo       <= quo_nx;
            dsr       <= dsr_nx;
            is_div    <= div_nx;
            neg_q     <= negq_nx;
            neg_r     <= negr_nx;
            div0      <= dz_nx;
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
`timescale 1ns/1ps
// Bench for alu_seq_param: WIDTH=32 and WIDTH=8 instances, each checked every
// cycle against a transaction-level model plus hand-computed literals.
module tb_alu_seq_param;
    localparam logic [5:0] OP_SLL   = 6'b000000;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLTU  = 6'b101011;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    typedef struct {
        logic [63:0] res, hi, lo, phi, plo;
        logic        zero, ovf, busy, done;
        int          left;
    } mstate_t;

    logic        clk = 1'b0;
    logic [1:0]  st, rs;
    logic [5:0]  opc [2];
    logic [63:0] ina [2];
    logic [63:0] inb [2];

    logic [31:0] res0, hi0, lo0;
    logic [7:0]  res1, hi1, lo1;
    logic [1:0]  o_zero, o_ovf, o_busy, o_done;

    int errors = 0;
    int checks = 0;

    mstate_t ms0, ms1;

    always #5 clk = ~clk;

    alu_seq_param #(.WIDTH(32)) dut32 (
        .Clk(clk), .Rst(rs[0]), .Start(st[0]), .ALUControl(opc[0]),
        .A(ina[0][31:0]), .B(inb[0][31:0]),
        .ALUResult(res0), .Zero(o_zero[0]), .Overflow(o_ovf[0]),
        .Hi(hi0), .Lo(lo0), .Busy(o_busy[0]), .Done(o_done[0])
    );

    alu_seq_param #(.WIDTH(8)) dut8 (
        .Clk(clk), .Rst(rs[1]), .Start(st[1]), .ALUControl(opc[1]),
        .A(ina[1][7:0]), .B(inb[1][7:0]),
        .ALUResult(res1), .Zero(o_zero[1]), .Overflow(o_ovf[1]),
        .Hi(hi1), .Lo(lo1), .Busy(o_busy[1]), .Done(o_done[1])
    );

    function automatic int wid(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    function automatic logic [63:0] mk(input int w);
        return (64'(1) << w) - 64'(1);
    endfunction

    function automatic logic signed [63:0] sx(input logic [63:0] v, input int w);
        logic [63:0] m;
        m = mk(w);
        return v[w-1] ? $signed(v | ~m) : $signed(v & m);
    endfunction

    function automatic logic [63:0] g_res(input int i);
        return (i == 0) ? 64'(res0) : 64'(res1);
    endfunction
    function automatic logic [63:0] g_hi(input int i);
        return (i == 0) ? 64'(hi0) : 64'(hi1);
    endfunction
    function automatic logic [63:0] g_lo(input int i);
        return (i == 0) ? 64'(lo0) : 64'(lo1);
    endfunction

    function automatic mstate_t mreset();
        mstate_t s;
        s.res = '0; s.hi = '0; s.lo = '0; s.phi = '0; s.plo = '0;
        s.zero = 1'b1; s.ovf = 1'b0; s.busy = 1'b0; s.done = 1'b0; s.left = 0;
        return s;
    endfunction

    // Architectural model: one call per rising clock edge
    function automatic mstate_t step(input mstate_t s, input int w, input logic start,
                                     input logic [5:0] op, input logic [63:0] a,
                                     input logic [63:0] b);
        mstate_t n;
        logic [63:0] m, r, p;
        logic signed [63:0] sa, sb;
        logic o;
        int amt;
        n = s;
        m = mk(w);
        sa = sx(a, w);
        sb = sx(b, w);
        amt = int'(b & 64'(w - 1));
        n.done = 1'b0;
        if (s.busy) begin
            n.left = s.left - 1;
            if (n.left == 0) begin
                n.hi = s.phi; n.lo = s.plo; n.res = s.plo;
                n.zero = (s.plo == 0); n.ovf = 1'b0; n.done = 1'b1; n.busy = 1'b0;
            end
        end else if (start) begin
            if (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU) begin
                if (op == OP_MULT || op == OP_MULTU) begin
                    p = (op == OP_MULT) ? 64'(sa * sb) : a * b;
                    n.phi = (p >> w) & m;
                    n.plo = p & m;
                end else if (b == 0) begin
                    n.plo = m;
                    n.phi = a;
                end else if (op == OP_DIV) begin
                    n.plo = 64'(sa / sb) & m;
                    n.phi = 64'(sa % sb) & m;
                end else begin
                    n.plo = a / b;
                    n.phi = a % b;
                end
                n.busy = 1'b1;
                n.left = w + 1;
            end else begin
                o = 1'b0;
                case (op)
                    OP_ADD:  begin r = (a + b) & m; o = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]); end
                    OP_SUB:  begin r = (a - b) & m; o = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]); end
                    OP_AND:  r = a & b;
                    OP_OR:   r = a | b;
                    OP_XOR:  r = a ^ b;
                    OP_NOR:  r = ~(a | b) & m;
                    OP_SLT:  r = (sa < sb) ? 64'(1) : 64'(0);
                    OP_SLTU: r = (a < b) ? 64'(1) : 64'(0);
                    OP_SLL:  r = (a << amt) & m;
                    OP_SRL:  r = a >> amt;
                    OP_SRA:  r = 64'(sa >>> amt) & m;
                    OP_MFHI: r = s.hi;
                    OP_MFLO: r = s.lo;
                    default: r = 0;
                endcase
                n.res = r; n.zero = (r == 0); n.ovf = o; n.done = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rs[0]) begin
        if (rs[0]) ms0 <= mreset();
        else       ms0 <= step(ms0, 32, st[0], opc[0], ina[0], inb[0]);
    end

    always @(posedge clk or posedge rs[1]) begin
        if (rs[1]) ms1 <= mreset();
        else       ms1 <= step(ms1, 8, st[1], opc[1], ina[1], inb[1]);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int i, input mstate_t s);
        string p;
        p = $sformatf("w%0d", wid(i));
        check({p, " model ALUResult"}, g_res(i), s.res);
        check({p, " model Zero"}, 64'(o_zero[i]), 64'(s.zero));
        check({p, " model Overflow"}, 64'(o_ovf[i]), 64'(s.ovf));
        check({p, " model Hi"}, g_hi(i), s.hi);
        check({p, " model Lo"}, g_lo(i), s.lo);
        check({p, " model Busy"}, 64'(o_busy[i]), 64'(s.busy));
        check({p, " model Done"}, 64'(o_done[i]), 64'(s.done));
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        cmp_inst(0, ms0);
        cmp_inst(1, ms1);
    end

    // Issue one op at the current negedge; returns one cycle later
    task automatic go(input int i, input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m;
        m = mk(wid(i));
        st[i] = 1'b1; opc[i] = op; ina[i] = a & m; inb[i] = b & m;
        @(negedge clk);
        st[i] = 1'b0;
    endtask

    // Wait for Done (bounded); optionally pulse add 1+1 at iteration inj
    task automatic wait_done(input int i, input int inj, output int lat, output int bcnt);
        lat = -1;
        bcnt = 0;
        for (int k = 1; k <= 100; k++) begin
            if (o_busy[i]) bcnt++;
            if (k == inj) begin
                st[i] = 1'b1; opc[i] = OP_ADD; ina[i] = 64'(1); inb[i] = 64'(1);
            end
            @(negedge clk);
            st[i] = 1'b0;
            if (o_done[i]) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("done timeout", 64'(0), 64'(1));
    endtask

    task automatic run(input int i);
        int w, lat, bc, nd;
        logic [63:0] m, top;
        string p;
        w = wid(i);
        m = mk(w);
        top = 64'(1) << (w - 1);
        p = $sformatf("w%0d", w);

        rs[i] = 1'b1;
        repeat (2) @(negedge clk);
        rs[i] = 1'b0;
        check({p, " reset res"}, g_res(i), 64'(0));
        check({p, " reset zero"}, 64'(o_zero[i]), 64'(1));
        check({p, " reset busy"}, 64'(o_busy[i]), 64'(0));

        go(i, OP_ADD, m >> 1, 64'(1));
        check({p, " add ovf res"}, g_res(i), top);
        check({p, " add ovf flag"}, 64'(o_ovf[i]), 64'(1));
        check({p, " add done"}, 64'(o_done[i]), 64'(1));
        go(i, OP_SUB, 64'(5), 64'(5));
        check({p, " sub res"}, g_res(i), 64'(0));
        check({p, " sub zero"}, 64'(o_zero[i]), 64'(1));
        check({p, " sub ovf"}, 64'(o_ovf[i]), 64'(0));
        go(i, OP_AND, 64'(15), 64'(14));
        check({p, " and"}, g_res(i), 64'(14));
        go(i, OP_NOR, 64'(5), 64'(2));
        check({p, " nor"}, g_res(i), ~64'(7) & m);
        go(i, OP_OR, 64'(9), 64'(6));
        go(i, OP_XOR, 64'(12), 64'(10));
        check({p, " xor"}, g_res(i), 64'(6));
        go(i, OP_SLT, -64'(2), 64'(3));
        check({p, " slt"}, g_res(i), 64'(1));
        go(i, OP_SLTU, -64'(2), 64'(3));
        check({p, " sltu"}, g_res(i), 64'(0));
        go(i, OP_SRA, top, 64'(4));
        check({p, " sra"}, g_res(i), ~((64'(1) << (w - 5)) - 64'(1)) & m);
        go(i, OP_SRL, top, 64'(4));
        check({p, " srl"}, g_res(i), top >> 4);
        go(i, OP_SLL, 64'(1), 64'(37));
        check({p, " sll"}, g_res(i), 64'(32));

        go(i, OP_MULT, -64'(3), 64'(7));
        wait_done(i, 5, lat, bc);
        check({p, " mult latency"}, 64'(lat), 64'(w + 1));
        check({p, " mult busy cycles"}, 64'(bc), 64'(w + 1));
        check({p, " mult hi"}, g_hi(i), m);
        check({p, " mult lo"}, g_lo(i), -64'(21) & m);
        check({p, " mult res"}, g_res(i), -64'(21) & m);
        go(i, OP_ADD, 64'(1), 64'(1));
        check({p, " add in done cycle"}, g_res(i), 64'(2));

        go(i, OP_MULTU, m, 64'(2));
        wait_done(i, -1, lat, bc);
        check({p, " multu hi"}, g_hi(i), 64'(1));
        check({p, " multu lo"}, g_lo(i), m - 64'(1));

        go(i, OP_DIVU, 64'(100), 64'(7));
        wait_done(i, -1, lat, bc);
        check({p, " divu lo"}, g_lo(i), 64'(14));
        check({p, " divu hi"}, g_hi(i), 64'(2));

        go(i, OP_DIV, -64'(7), 64'(2));
        wait_done(i, -1, lat, bc);
        check({p, " div lo"}, g_lo(i), -64'(3) & m);
        check({p, " div hi"}, g_hi(i), m);

        go(i, OP_BAD, 64'(3), 64'(4));
        check({p, " unknown res"}, g_res(i), 64'(0));
        check({p, " unknown done"}, 64'(o_done[i]), 64'(1));

        go(i, OP_DIV, 64'(9), 64'(0));
        wait_done(i, -1, lat, bc);
        check({p, " div0 lo"}, g_lo(i), m);
        check({p, " div0 hi"}, g_hi(i), 64'(9));
        go(i, OP_MFLO, 64'(0), 64'(0));
        check({p, " mflo"}, g_res(i), m);
        go(i, OP_MFHI, 64'(0), 64'(0));
        check({p, " mfhi"}, g_res(i), 64'(9));

        go(i, OP_DIVU, 64'(100), 64'(7));
        repeat (10) @(negedge clk);
        #2 rs[i] = 1'b1;
        #1;
        check({p, " midop rst busy"}, 64'(o_busy[i]), 64'(0));
        check({p, " midop rst hi"}, g_hi(i), 64'(0));
        check({p, " midop rst lo"}, g_lo(i), 64'(0));
        check({p, " midop rst res"}, g_res(i), 64'(0));
        @(negedge clk);
        rs[i] = 1'b0;
        nd = 0;
        for (int k = 0; k < w + 4; k++) begin
            @(negedge clk);
            if (o_done[i]) nd++;
        end
        check({p, " no done after abort"}, 64'(nd), 64'(0));

        go(i, OP_MULT, 64'(3), 64'(3));
        wait_done(i, -1, lat, bc);
        check({p, " mult3x3 latency"}, 64'(lat), 64'(w + 1));
        check({p, " mult3x3 lo"}, g_lo(i), 64'(9));
        check({p, " mult3x3 hi"}, g_hi(i), 64'(0));
        @(negedge clk);
    endtask

    initial begin
        rs = 2'b11;
        st = 2'b00;
        for (int i = 0; i < 2; i++) begin
            opc[i] = '0;
            ina[i] = '0;
            inb[i] = '0;
        end
        repeat (2) @(negedge clk);
        run(0);
        run(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq_param.md
# alu_seq_param

Parametrised successor to the 32-bit datapath ALU: a WIDTH-bit registered ALU with an explicit start/done handshake, single-cycle logic, arithmetic and shift ops, and iterative multi-cycle multiply/divide writing HI/LO registers. It sits in the EX stage of the MIPS-style processor. The pipeline stalls on `Busy` while a multiply or divide is in flight.

## Interface
- `WIDTH`, 32, operand/result width; ≥ 4, power of two.
- `Clk`  in  1  rising-edge clock.
- `Rst`  in  1  asynchronous, active-high reset.
- `Start`  in  1  request; sampled only when `Busy`=0.
- `ALUControl`  in  6  operation code, sampled with `Start`.
- `A`, `B`  in  WIDTH each  operands, sampled with `Start`.
- `ALUResult`  out  WIDTH  registered result.
- `Zero`  out  1  registered; 1 iff `ALUResult`==0.
- `Overflow`  out  1  registered signed overflow for add/sub; 0 otherwise.
- `Hi`, `Lo`  out  WIDTH each  HI/LO architectural registers.
- `Busy`  out  1  multi-cycle op in progress.
- `Done`  out  1  one-cycle pulse when `ALUResult` is updated.

## Operation
- Opcodes, single-cycle:
  - `100000` add, `100010` sub (both two's complement, wrap modulo 2^WIDTH).
  - `100100` and, `100101` or, `100110` xor, `100111` nor.
  - `101010` slt (signed), `101011` sltu: result is 1 or 0, zero-extended.
  - Shifts use amount B[log2(WIDTH)-1:0]: `000000` sll A, `000010` srl A, `000011` sra A.
  - `010000` mfhi (result = `Hi`), `010010` mflo (result = `Lo`).
- Opcodes, multi-cycle: `011000` mult, `011001` multu, `011010` div, `011011` divu.
- Unknown opcode: result 0, `Zero`=1, `Done` pulses, `Hi`/`Lo` unchanged.
- `Overflow` is set on add when the operand signs match and the result sign differs. On sub it is set when the operand signs differ and the result sign differs from A. It is cleared on every other op.
- State machine: IDLE → CALC → FIX → IDLE.
  - IDLE: on `Start`, a single-cycle op registers its result and pulses `Done`. A multi-cycle op latches the operand magnitudes (signed ops) or raw operands (unsigned ops) plus the result signs, loads counter=WIDTH, and sets `Busy`.
  - CALC: one iteration per cycle, counter decrements, exits at 0.
    - Multiply: shift-add, one multiplier bit per cycle, into a 2·WIDTH product.
    - Divide: restoring, one quotient bit per cycle.
  - FIX: applies sign correction.
    - mult: negate the 2·WIDTH product if the signs differ.
    - div: quotient negative if the signs differ; remainder takes the dividend's sign, truncating toward zero.
    - Writes `Hi`/`Lo`, sets `ALUResult`=`Lo`, pulses `Done`, clears `Busy`.
- Product split: `Hi` = upper WIDTH bits, `Lo` = lower.
- Division: `Lo` = quotient, `Hi` = remainder.
- Divide by zero: `Lo` = all ones, `Hi` = A. Normal latency applies and no trap is raised.
- `Start` while `Busy`=1 is ignored, with no queuing and no effect on the operation in flight.
- `Hi`/`Lo` change only in FIX. mfhi/mflo issued in the same cycle as a FIX `Done` is accepted (`Busy` is already 0) and reads the newly written values.

## Timing
- Reset (async, immediate): `ALUResult`=0, `Zero`=1, `Overflow`=0, `Hi`=0, `Lo`=0, `Busy`=0, `Done`=0, state=IDLE, counter=0.
- Reset mid-operation aborts the op and `Done` is never produced for it.
- Single-cycle op, `Start` sampled at edge E0: result, `Zero`, `Overflow` and `Done`=1 are visible after E0, so latency is 1. `Done` falls after E1 unless a new single-cycle `Start` is sampled at E1.
- Multi-cycle op, `Start` sampled at E0:
  - `Busy`=1 after E0.
  - CALC runs edges E1..E_WIDTH.
  - FIX at E_{WIDTH+1}: `Done`=1 and `Busy`=0 after it, so latency is WIDTH+1 (33 at default).
- Back-to-back: a new `Start` is accepted in the cycle `Done` is high.
- `ALUResult`, `Zero` and `Overflow` hold their last value while `Busy` and while idle.

## Test plan
- Reset and arithmetic: assert `Rst` asynchronously mid-cycle → all outputs take reset values at once.
  - add 0x7FFFFFFF+1 → 0x80000000, `Overflow`=1, `Done` 1 cycle later.
  - sub 5−5 → 0, `Zero`=1, `Overflow`=0.
- Logic/compare/shift:
  - and 15&14 → 14; nor 5,2 → 0xFFFFFFF8.
  - slt −2,3 → 1; sltu 0xFFFFFFFE,3 → 0.
  - sra 0x80000000 by 4 → 0xF8000000; srl same → 0x08000000; sll 1 by 37 (amount 5) → 0x20.
- Multiply:
  - mult −3×7 → `Hi`=0xFFFFFFFF, `Lo`=0xFFFFFFEB, `Busy` for 33 cycles, `Done` exactly 33 cycles after `Start`.
  - multu 0xFFFFFFFF×2 → `Hi`=1, `Lo`=0xFFFFFFFE.
- Divide:
  - divu 100/7 → `Lo`=14, `Hi`=2.
  - div −7/2 → `Lo`=0xFFFFFFFD, `Hi`=0xFFFFFFFF.
  - div 9/0 → `Lo`=0xFFFFFFFF, `Hi`=9.
  - then mflo → `ALUResult`=0xFFFFFFFF.
- Handshake: during a mult, pulse `Start` with add 1+1 → ignored, result unchanged.
  - Issue add 1+1 in the `Done` cycle → 2 is visible one cycle later.
- Reset mid-op: `Rst` at CALC cycle 10 of a div → `Busy`=0, `Hi`=`Lo`=0, no `Done`.
  - A following mult 3×3 → `Lo`=9 with normal latency.
- Rerun all scenarios at WIDTH=8: mult −3×7 → `Hi`=0xFF, `Lo`=0xEB, latency 9.
